dmem_stage_pipe: RTL and testbench

- Parametrised data-memory stage for the pipelined core: DATA_W x DEPTH synchronous RAM with 1-cycle registered reads.
- Stores are selected through a store-data forwarding mux, then committed through a WR_LAT-deep write pipeline.
- Loads see the youngest in-flight store to the same address (store-to-load bypass), so back-to-back store/load needs no stall.
- Sits between EX/MEM and MEM/WB pipeline registers.

---
 rtl/dmem_stage_pipe.sv | 131 +++++++++++++
 tb/tb_dmem_stage_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage_pipe.sv
// Data-memory stage: synchronous RAM, WR_LAT-deep store commit pipeline, store-to-load bypass.
// Optional macro DMEM_BOUNDS_CHECK_EN rejects addresses >= DEPTH and pulses addr_fault.
module dmem_stage_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] fwd_alu_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [2:0]        pending_cnt,
  output logic              rw_conflict,
  output logic              addr_fault
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [WR_LAT-1:0] pipe_valid;
  logic [IDX_W-1:0]  pipe_idx  [WR_LAT];
  logic [DATA_W-1:0] pipe_data [WR_LAT];

  logic [IDX_W-1:0]  idx;
  logic              out_of_range;
  logic              store_go;
  logic              load_go;
  logic [DATA_W-1:0] store_data;
  logic [WR_LAT-1:0] next_valid;
  logic [2:0]        next_cnt;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign idx = addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
`else
  // Upper address bits are intentionally ignored: indices wrap modulo DEPTH.
  logic addr_unused;
  assign addr_unused  = ^addr;
  assign out_of_range = 1'b0;
`endif

  // A simultaneous read+write lets the store through and drops the load.
  assign store_go = mem_write & ~out_of_range;
  assign load_go  = mem_read & ~mem_write;

  always_comb begin
    case (forward_b)
      2'b10:   store_data = fwd_alu_data;
      2'b01:   store_data = fwd_wb_data;
      default: store_data = write_data;
    endcase
  end

  always_comb begin
    next_valid    = '0;
    next_valid[0] = store_go;
    for (int i = 1; i < WR_LAT; i++) begin
      next_valid[i] = pipe_valid[i-1];
    end
    next_cnt = '0;
    for (int i = 0; i < WR_LAT; i++) begin
      next_cnt = next_cnt + 3'(next_valid[i]);
    end
  end

  // Oldest stage scanned first so younger matches overwrite; the commit stage is included.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = WR_LAT - 1; i >= 0; i--) begin
      if (pipe_valid[i] && (pipe_idx[i] == idx)) begin
        hit      = 1'b1;
        hit_data = pipe_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && pipe_valid[WR_LAT-1]) begin
      mem[pipe_idx[WR_LAT-1]] <= pipe_data[WR_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_idx[0]  <= idx;
    pipe_data[0] <= store_data;
    for (int i = 1; i < WR_LAT; i++) begin
      pipe_idx[i]  <= pipe_idx[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid  <= '0;
      read_data   <= '0;
      read_valid  <= 1'b0;
      pending_cnt <= '0;
      rw_conflict <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      pipe_valid  <= next_valid;
      pending_cnt <= next_cnt;
      rw_conflict <= mem_read & mem_write;
      addr_fault  <= (mem_read | mem_write) & out_of_range;
      read_valid  <= load_go;
      if (load_go) begin
        if (out_of_range) begin
          read_data <= '0;
        end else if (hit) begin
          read_data <= hit_data;
        end else begin
          read_data <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_stage_pipe.sv
// Directed bench for dmem_stage_pipe: driver tasks push expected load data, a monitor pops on read_valid.
module tb_dmem_stage_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [7:0] addr = '0;
  logic [1:0] forward_b = '0;
  logic [7:0] write_data = '0;
  logic [7:0] fwd_alu_data = '0;
  logic [7:0] fwd_wb_data = '0;
  logic [7:0] read_data;
  logic       read_valid;
  logic [2:0] pending_cnt;
  logic       rw_conflict;
  logic       addr_fault;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;

  dmem_stage_pipe #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(128), .WR_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .forward_b(forward_b), .write_data(write_data),
    .fwd_alu_data(fwd_alu_data), .fwd_wb_data(fwd_wb_data),
    .read_data(read_data), .read_valid(read_valid), .pending_cnt(pending_cnt),
    .rw_conflict(rw_conflict), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [1:0] fb,
                       input logic [7:0] wd, input logic [7:0] alu, input logic [7:0] wb);
    @(posedge clk);
    #1;
    mem_read = rd;
    mem_write = wr;
    addr = a;
    forward_b = fb;
    write_data = wd;
    fwd_alu_data = alu;
    fwd_wb_data = wb;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, a, 2'b00, d, 8'h00, 8'h00);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] e);
    drive(1'b1, 1'b0, a, 2'b00, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(e);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  // Monitor: every read_valid must match the oldest outstanding expected load value.
  always @(negedge clk) begin
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_read: got 0x%0h expected no response", read_data);
      end else begin
        check("read_data", read_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 0);
    check("rst_read_valid", read_valid, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_rw_conflict", rw_conflict, 0);
    check("rst_addr_fault", addr_fault, 0);
    reset = 1'b0;

    load(8'h10, 8'h00);
    nop();
    check("pending_idle", pending_cnt, 0);

    // Store then load next cycle: served by bypass, then later from the array.
    store(8'h20, 8'hA5);
    load(8'h20, 8'hA5);
    check("pending_one_a", pending_cnt, 1);
    nop();
    check("pending_one_b", pending_cnt, 1);
    nop();
    check("pending_drain1", pending_cnt, 0);
    load(8'h20, 8'hA5);

    // Two stores to the same index: youngest wins in bypass and in the array.
    store(8'h30, 8'h11);
    store(8'h30, 8'h22);
    load(8'h30, 8'h22);
    check("pending_two", pending_cnt, 2);
    nop();
    nop();
    nop();
    check("pending_drain2", pending_cnt, 0);
    load(8'h30, 8'h22);

    // Store-data forwarding mux.
    drive(1'b0, 1'b1, 8'h40, 2'b10, 8'h01, 8'h7E, 8'h99);
    nop();
    nop();
    nop();
    load(8'h40, 8'h7E);
    drive(1'b0, 1'b1, 8'h41, 2'b01, 8'h01, 8'h77, 8'h3C);
    nop();
    nop();
    nop();
    load(8'h41, 8'h3C);
    drive(1'b0, 1'b1, 8'h42, 2'b11, 8'h5A, 8'hEE, 8'hDD);
    load(8'h42, 8'h5A);

    // Reset one cycle after a store discards it; a load in the reset cycle returns nothing.
    store(8'h50, 8'h55);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_write = 1'b0;
    mem_read = 1'b1;
    addr = 8'h10;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_read = 1'b0;
    check("pending_after_rst", pending_cnt, 0);
    check("valid_after_rst", read_valid, 0);
    load(8'h50, 8'h00);
    nop();

    // Simultaneous read+write: store proceeds, load dropped, conflict pulses once.
    drive(1'b1, 1'b1, 8'h60, 2'b00, 8'h66, 8'h00, 8'h00);
    nop();
    check("rw_conflict_hi", rw_conflict, 1);
    check("conflict_no_valid", read_valid, 0);
    nop();
    check("rw_conflict_lo", rw_conflict, 0);
    load(8'h60, 8'h66);

`ifdef DMEM_BOUNDS_CHECK_EN
    store(8'h90, 8'h9A);
    nop();
    check("fault_store", addr_fault, 1);
    check("fault_pending", pending_cnt, 0);
    nop();
    check("fault_clear", addr_fault, 0);
    load(8'h90, 8'h00);
    nop();
    check("fault_load", addr_fault, 1);
    load(8'h10, 8'h00);
`else
    store(8'h90, 8'h9A);
    nop();
    check("nofault_store", addr_fault, 0);
    check("wrap_pending", pending_cnt, 1);
    nop();
    nop();
    load(8'h10, 8'h9A);
    store(8'h91, 8'h3D);
    load(8'h11, 8'h3D);
`endif

    repeat (4) nop();
    check("outstanding_loads", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
